teclado_atm: RTL and testbench

Keypad front-end that sits directly upstream of the card controller and produces its digito/digito_stb and monto/monto_stb inputs. It debounces raw key events and passes PIN digits one strobe per key press. In amount mode it accumulates decimal keys into a binary amount and releases the amount on an enter key. Session scope follows tarjeta_recibida: when the card is removed, all entry state is discarded.

---
 rtl/teclado_atm.sv | 176 +++++++++++++++++
 tb/tb_teclado_atm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/teclado_atm.sv
// rtl/teclado_atm.sv - debounced ATM keypad front-end producing PIN digit and amount strobes
module teclado_atm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PIN_DIGITOS     = 4,
  parameter int MAX_DIGITOS     = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tarjeta_recibida,
  input  logic        modo_monto,
  input  logic [3:0]  tecla,
  input  logic        tecla_valida,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        pin_completo,
  output logic        error_tecla
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PIN_DIGITOS + 1);
  localparam int MW = $clog2(MAX_DIGITOS + 1);

  typedef enum logic [1:0] {IDLE, PIN, PIN_DONE, MONTO} state_t;

  state_t        state, state_n;
  logic [DW-1:0] db_cnt, db_cnt_n;
  logic          db_held, db_held_n;
  logic [3:0]    db_tecla, db_tecla_n;
  logic [PW-1:0] pin_cnt, pin_cnt_n;
  logic [MW-1:0] mon_cnt, mon_cnt_n;
  logic [31:0]   acc, acc_n, acc_x10;
  logic [3:0]    digito_n;
  logic [31:0]   monto_n;
  logic          digito_stb_n, monto_stb_n, pin_completo_n, error_n, evt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      db_cnt       <= '0;
      db_held      <= 1'b1;
      db_tecla     <= '0;
      pin_cnt      <= '0;
      mon_cnt      <= '0;
      acc          <= '0;
      digito       <= '0;
      digito_stb   <= 1'b0;
      monto        <= '0;
      monto_stb    <= 1'b0;
      pin_completo <= 1'b0;
      error_tecla  <= 1'b0;
    end else begin
      state        <= state_n;
      db_cnt       <= db_cnt_n;
      db_held      <= db_held_n;
      db_tecla     <= db_tecla_n;
      pin_cnt      <= pin_cnt_n;
      mon_cnt      <= mon_cnt_n;
      acc          <= acc_n;
      digito       <= digito_n;
      digito_stb   <= digito_stb_n;
      monto        <= monto_n;
      monto_stb    <= monto_stb_n;
      pin_completo <= pin_completo_n;
      error_tecla  <= error_n;
    end
  end

  always_comb begin
    state_n        = state;
    db_cnt_n       = db_cnt;
    db_held_n      = db_held;
    db_tecla_n     = db_tecla;
    pin_cnt_n      = pin_cnt;
    mon_cnt_n      = mon_cnt;
    acc_n          = acc;
    digito_n       = digito;
    monto_n        = monto;
    digito_stb_n   = 1'b0;
    monto_stb_n    = 1'b0;
    pin_completo_n = pin_completo;
    error_n        = 1'b0;
    evt            = 1'b0;
    acc_x10        = (acc << 3) + (acc << 1);

    // db_held=1 means a press was taken (or state changed) and a clean release is owed
    if (!db_held) begin
      if (tecla_valida) begin
        db_tecla_n = tecla;
        if (db_cnt != '0 && tecla == db_tecla) db_cnt_n = db_cnt + DW'(1);
        else                                   db_cnt_n = DW'(1);
        if (db_cnt_n == DW'(DEBOUNCE_CYCLES)) begin
          evt       = 1'b1;
          db_held_n = 1'b1;
          db_cnt_n  = '0;
        end
      end else begin
        db_cnt_n = '0;
      end
    end else begin
      if (!tecla_valida) begin
        db_cnt_n = db_cnt + DW'(1);
        if (db_cnt_n == DW'(DEBOUNCE_CYCLES)) begin
          db_held_n = 1'b0;
          db_cnt_n  = '0;
        end
      end else begin
        db_cnt_n = '0;
      end
    end

    if (!tarjeta_recibida) begin
      state_n        = IDLE;
      pin_completo_n = 1'b0;
      pin_cnt_n      = '0;
      mon_cnt_n      = '0;
      acc_n          = '0;
    end else begin
      case (state)
        IDLE: state_n = modo_monto ? MONTO : PIN;
        PIN, PIN_DONE: begin
          if (modo_monto) begin
            state_n   = MONTO;
            acc_n     = '0;
            mon_cnt_n = '0;
          end else if (evt && state == PIN) begin
            digito_n     = tecla;
            digito_stb_n = 1'b1;
            pin_cnt_n    = pin_cnt + PW'(1);
            if (pin_cnt_n == PW'(PIN_DIGITOS)) begin
              pin_completo_n = 1'b1;
              state_n        = PIN_DONE;
            end
          end
        end
        MONTO: begin
          if (!modo_monto) begin
            state_n = pin_completo ? PIN_DONE : PIN;
          end else if (evt) begin
            if (tecla <= 4'd9) begin
              if (mon_cnt == MW'(MAX_DIGITOS)) begin
                error_n = 1'b1;
              end else begin
                acc_n     = acc_x10 + {28'd0, tecla};
                mon_cnt_n = mon_cnt + MW'(1);
              end
            end else if (tecla == 4'hA) begin
              acc_n     = '0;
              mon_cnt_n = '0;
            end else if (tecla == 4'hB) begin
              if (mon_cnt != '0) begin
                monto_n     = acc;
                monto_stb_n = 1'b1;
                acc_n       = '0;
                mon_cnt_n   = '0;
              end else begin
                error_n = 1'b1;
              end
            end else begin
              error_n = 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end

    // Any state change discards a key that is still held down
    if (state_n != state) begin
      db_cnt_n  = '0;
      db_held_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_teclado_atm.sv
// tb/tb_teclado_atm.sv - scoreboard bench for teclado_atm
module tb_teclado_atm;

  logic        clk, rst, tarjeta_recibida, modo_monto, tecla_valida;
  logic [3:0]  tecla, digito;
  logic [31:0] monto;
  logic        digito_stb, monto_stb, pin_completo, error_tecla;

  typedef struct {
    int          kind;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam int K_DIG = 0;
  localparam int K_MON = 1;
  localparam int K_ERR = 2;
  localparam int K_NONE = -1;

  teclado_atm dut (
    .clk(clk), .rst(rst), .tarjeta_recibida(tarjeta_recibida), .modo_monto(modo_monto),
    .tecla(tecla), .tecla_valida(tecla_valida), .digito(digito), .digito_stb(digito_stb),
    .monto(monto), .monto_stb(monto_stb), .pin_completo(pin_completo), .error_tecla(error_tecla)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst === 1'b1 && (digito_stb || monto_stb || error_tecla)) begin
      exp_t        e;
      int          ak;
      logic [31:0] av;
      checks++;
      if ($countones({digito_stb, monto_stb, error_tecla}) > 1) begin
        errors++;
        $display("FAIL multi_strobe cyc=%0d d=%b m=%b e=%b required one", cyc, digito_stb, monto_stb, error_tecla);
      end
      ak = digito_stb ? K_DIG : (monto_stb ? K_MON : K_ERR);
      av = digito_stb ? {28'd0, digito} : (monto_stb ? monto : 32'd0);
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cyc=%0d kind=%0d val=%0d required none", cyc, ak, av);
      end else begin
        e = sbq.pop_front();
        if (ak != e.kind || av !== e.val || cyc != e.cyc)
          begin
            errors++;
            $display("FAIL strobe kind=%0d val=%0d cyc=%0d required kind=%0d val=%0d cyc=%0d",
                     ak, av, cyc, e.kind, e.val, e.cyc);
          end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int kind, input logic [31:0] val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    if (kind != K_NONE) sbq.push_back(e);
  endtask

  // clean press: held 8 edges, released 8 edges; response due on the 4th sampling edge
  task automatic press(input logic [3:0] key, input int kind, input logic [31:0] val);
    @(posedge clk);
    #1;
    tecla        = key;
    tecla_valida = 1'b1;
    expect_at(kind, val, cyc + 4);
    step(8);
    tecla_valida = 1'b0;
    step(8);
  endtask

  task automatic set_mode(input logic card, input logic mode);
    tarjeta_recibida = card;
    modo_monto       = mode;
    step(6);
  endtask

  logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b0; tarjeta_recibida = 1'b1; modo_monto = 1'b0; tecla = 4'h5; tecla_valida = 1'b1;
    step(2);
    check("rst_digito", {28'd0, digito}, 32'd0);
    check("rst_digito_stb", {31'd0, digito_stb}, 32'd0);
    check("rst_monto", monto, 32'd0);
    check("rst_monto_stb", {31'd0, monto_stb}, 32'd0);
    check("rst_pin_completo", {31'd0, pin_completo}, 32'd0);
    check("rst_error_tecla", {31'd0, error_tecla}, 32'd0);
    rst = 1'b1;
    step(10);
    tecla_valida = 1'b0;
    step(8);

    press(4'hD, K_DIG, 32'hD);
    press(4'h4, K_DIG, 32'h4);
    press(4'hD, K_DIG, 32'hD);
    check("pin_completo_early", {31'd0, pin_completo}, 32'd0);
    press(4'hD, K_DIG, 32'hD);
    check("pin_completo_set", {31'd0, pin_completo}, 32'd1);
    press(4'h7, K_NONE, 32'd0);
    check("digito_hold", {28'd0, digito}, 32'hD);

    set_mode(1'b1, 1'b1);
    press(4'h2, K_NONE, 32'd0);
    for (int i = 0; i < 4; i++) press(4'h0, K_NONE, 32'd0);
    press(4'hB, K_MON, 32'd20000);
    press(4'hB, K_ERR, 32'd0);
    check("monto_after_err", monto, 32'h4E20);

    for (int i = 0; i < 9; i++) press(4'h9, K_NONE, 32'd0);
    press(4'h9, K_ERR, 32'd0);
    press(4'hB, K_MON, 32'd999999999);
    press(4'h5, K_NONE, 32'd0);
    press(4'hA, K_NONE, 32'd0);
    press(4'h7, K_NONE, 32'd0);
    press(4'hB, K_MON, 32'd7);
    press(4'hE, K_ERR, 32'd0);

    press(4'h1, K_NONE, 32'd0);
    press(4'h2, K_NONE, 32'd0);
    set_mode(1'b0, 1'b1);
    check("idle_pin_completo", {31'd0, pin_completo}, 32'd0);
    check("idle_monto_hold", monto, 32'd7);
    set_mode(1'b1, 1'b1);
    press(4'h3, K_NONE, 32'd0);
    press(4'hB, K_MON, 32'd3);

    set_mode(1'b0, 1'b1);
    set_mode(1'b1, 1'b0);
    @(posedge clk);
    #1;
    tecla = 4'h1;
    expect_at(K_DIG, 32'h1, cyc + 9);
    for (int i = 0; i < 9; i++) begin
      tecla_valida = pat[i];
      step(1);
    end
    step(6);
    tecla_valida = 1'b0;
    step(8);
    check("bounce_pin_completo", {31'd0, pin_completo}, 32'd0);

    step(4);
    check("sb_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
